// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the I2C register sequencer: core register map,
// command bytes, status bit positions, error codes and FSM states.
package i2c_seq_pkg;

   localparam logic [2:0] ADR_PRERLO = 3'd0;
   localparam logic [2:0] ADR_PRERHI = 3'd1;
   localparam logic [2:0] ADR_CTR    = 3'd2;
   localparam logic [2:0] ADR_TXR    = 3'd3;
   localparam logic [2:0] ADR_RXR    = 3'd3;
   localparam logic [2:0] ADR_CR     = 3'd4;
   localparam logic [2:0] ADR_SR     = 3'd4;

   localparam logic [7:0] CTR_EN = 8'h80;

   localparam logic [7:0] CR_STA_WR      = 8'h90;
   localparam logic [7:0] CR_WR          = 8'h10;
   localparam logic [7:0] CR_WR_STO      = 8'h50;
   localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
   localparam logic [7:0] CR_STO         = 8'h40;

   localparam int unsigned SR_RXACK = 7;
   localparam int unsigned SR_BUSY  = 6;
   localparam int unsigned SR_AL    = 5;
   localparam int unsigned SR_TIP   = 1;

   typedef enum logic [1:0] {
      ErrOk      = 2'd0,
      ErrNack    = 2'd1,
      ErrArb     = 2'd2,
      ErrTimeout = 2'd3
   } err_e;

   typedef enum logic [3:0] {
      StInit,
      StIdle,
      StSetTxr,
      StSetCr,
      StPoll,
      StGetRx,
      StStopCr,
      StStopPoll,
      StDone
   } state_e;

   // Command byte for each transaction phase; phase 3 only exists for reads.
   function automatic logic [7:0] phase_cr(input logic rnw, input logic [1:0] idx);
      logic [7:0] cr;
      case (idx)
         2'd0:    cr = CR_STA_WR;
         2'd1:    cr = CR_WR;
         2'd2:    cr = rnw ? CR_STA_WR : CR_WR_STO;
         default: cr = CR_RD_NACK_STO;
      endcase
      return cr;
   endfunction

   function automatic logic [7:0] phase_txr(input logic rnw, input logic [1:0] idx,
                                            input logic [6:0] dev, input logic [7:0] regaddr,
                                            input logic [7:0] wdata);
      logic [7:0] txr;
      case (idx)
         2'd0:    txr = {dev, 1'b0};
         2'd1:    txr = regaddr;
         default: txr = rnw ? {dev, 1'b1} : wdata;
      endcase
      return txr;
   endfunction

endpackage

// File: rtl/i2c_wb_access.sv
// Single-access Wishbone master: latches adr/dat/we on start, holds the strobe until
// ack, then pulses done with the captured read data.
module i2c_wb_access
   import i2c_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] adr,
   input  logic [7:0] dat,
   input  logic       we,
   output logic       done,
   output logic [7:0] rdata,
   output logic [2:0] bus_adr,
   output logic [7:0] bus_dat,
   output logic       bus_we,
   output logic       bus_stb,
   input  logic [7:0] bus_rdat,
   input  logic       bus_ack
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done    <= 1'b0;
         rdata   <= 8'h00;
         bus_adr <= 3'd0;
         bus_dat <= 8'h00;
         bus_we  <= 1'b0;
         bus_stb <= 1'b0;
      end else begin
         done <= 1'b0;
         if (bus_stb) begin
            if (bus_ack) begin
               bus_stb <= 1'b0;
               done    <= 1'b1;
               rdata   <= bus_rdat;
            end
         end else if (start) begin
            bus_stb <= 1'b1;
            bus_adr <= adr;
            bus_dat <= dat;
            bus_we  <= we;
         end
      end
   end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Register-level I2C transaction sequencer for the OpenCores I2C master: programs the
// prescaler after reset, then runs single-byte register writes/reads from req/done.
module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter logic [15:0] PRESCALE     = 16'h0035,
   parameter logic [19:0] POLL_TIMEOUT = 20'd1000000
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       req_i,
   input  logic       req_rnw_i,
   input  logic [6:0] req_dev_i,
   input  logic [7:0] req_reg_i,
   input  logic [7:0] req_wdata_i,
   output logic       ready_o,
   output logic       done_o,
   output logic [1:0] err_o,
   output logic [7:0] rdata_o,
   output logic [2:0] m_adr_o,
   output logic [7:0] m_dat_o,
   output logic       m_we_o,
   output logic       m_stb_o,
   input  logic [7:0] m_dat_i,
   input  logic       m_ack_i
);

   state_e      state;
   logic [1:0]  phase;
   logic        rnw;
   logic [6:0]  dev;
   logic [7:0]  regaddr;
   logic [7:0]  wdata;
   logic [19:0] cnt;
   logic        start;
   logic [2:0]  acc_adr;
   logic [7:0]  acc_dat;
   logic        acc_we;
   logic        acc_done;
   logic [7:0]  acc_rdata;
   logic [1:0]  last_phase;

   assign last_phase = rnw ? 2'd3 : 2'd2;

   i2c_wb_access u_access (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .start    (start),
      .adr      (acc_adr),
      .dat      (acc_dat),
      .we       (acc_we),
      .done     (acc_done),
      .rdata    (acc_rdata),
      .bus_adr  (m_adr_o),
      .bus_dat  (m_dat_o),
      .bus_we   (m_we_o),
      .bus_stb  (m_stb_o),
      .bus_rdat (m_dat_i),
      .bus_ack  (m_ack_i)
   );

   // Every transition into a bus state loads acc_* and pulses start in the same edge,
   // so the strobe rises the cycle after state entry.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state   <= StInit;
         phase   <= 2'd0;
         rnw     <= 1'b0;
         dev     <= 7'd0;
         regaddr <= 8'h00;
         wdata   <= 8'h00;
         cnt     <= 20'd0;
         start   <= 1'b1;
         acc_adr <= ADR_PRERLO;
         acc_dat <= PRESCALE[7:0];
         acc_we  <= 1'b1;
         ready_o <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= ErrOk;
         rdata_o <= 8'h00;
      end else begin
         start  <= 1'b0;
         done_o <= 1'b0;
         if ((state == StPoll || state == StStopPoll) && cnt != POLL_TIMEOUT) begin
            cnt <= cnt + 20'd1;
         end
         case (state)
            StInit: if (acc_done) begin
               if (phase == 2'd2) begin
                  state   <= StIdle;
                  phase   <= 2'd0;
                  ready_o <= 1'b1;
               end else begin
                  phase   <= phase + 2'd1;
                  start   <= 1'b1;
                  acc_adr <= (phase == 2'd0) ? ADR_PRERHI : ADR_CTR;
                  acc_dat <= (phase == 2'd0) ? PRESCALE[15:8] : CTR_EN;
               end
            end
            StIdle: if (req_i) begin
               rnw     <= req_rnw_i;
               dev     <= req_dev_i;
               regaddr <= req_reg_i;
               wdata   <= req_wdata_i;
               ready_o <= 1'b0;
               err_o   <= ErrOk;
               phase   <= 2'd0;
               state   <= StSetTxr;
               start   <= 1'b1;
               acc_adr <= ADR_TXR;
               acc_dat <= {req_dev_i, 1'b0};
               acc_we  <= 1'b1;
            end
            StSetTxr: if (acc_done) begin
               state   <= StSetCr;
               start   <= 1'b1;
               acc_adr <= ADR_CR;
               acc_dat <= phase_cr(rnw, phase);
               acc_we  <= 1'b1;
            end
            StSetCr: if (acc_done) begin
               state   <= StPoll;
               cnt     <= 20'd0;
               start   <= 1'b1;
               acc_adr <= ADR_SR;
               acc_dat <= 8'h00;
               acc_we  <= 1'b0;
            end
            StPoll: if (acc_done) begin
               if (!acc_rdata[SR_TIP]) begin
                  if (acc_rdata[SR_AL]) begin
                     err_o   <= ErrArb;
                     state   <= StStopCr;
                     start   <= 1'b1;
                     acc_adr <= ADR_CR;
                     acc_dat <= CR_STO;
                     acc_we  <= 1'b1;
                  end else if (acc_rdata[SR_RXACK] && phase != 2'd3) begin
                     err_o   <= ErrNack;
                     state   <= StStopCr;
                     start   <= 1'b1;
                     acc_adr <= ADR_CR;
                     acc_dat <= CR_STO;
                     acc_we  <= 1'b1;
                  end else if (phase == last_phase) begin
                     if (rnw) begin
                        state   <= StGetRx;
                        start   <= 1'b1;
                        acc_adr <= ADR_RXR;
                        acc_we  <= 1'b0;
                     end else begin
                        state <= StDone;
                     end
                  end else begin
                     phase   <= phase + 2'd1;
                     start   <= 1'b1;
                     acc_we  <= 1'b1;
                     // The final read phase issues only a command, no TXR byte.
                     if (rnw && phase == 2'd2) begin
                        state   <= StSetCr;
                        acc_adr <= ADR_CR;
                        acc_dat <= CR_RD_NACK_STO;
                     end else begin
                        state   <= StSetTxr;
                        acc_adr <= ADR_TXR;
                        acc_dat <= phase_txr(rnw, phase + 2'd1, dev, regaddr, wdata);
                     end
                  end
               end else if (cnt >= POLL_TIMEOUT) begin
                  err_o   <= ErrTimeout;
                  state   <= StStopCr;
                  start   <= 1'b1;
                  acc_adr <= ADR_CR;
                  acc_dat <= CR_STO;
                  acc_we  <= 1'b1;
               end else begin
                  start <= 1'b1;
               end
            end
            StGetRx: if (acc_done) begin
               rdata_o <= acc_rdata;
               state   <= StDone;
            end
            StStopCr: if (acc_done) begin
               state   <= StStopPoll;
               cnt     <= 20'd0;
               start   <= 1'b1;
               acc_adr <= ADR_SR;
               acc_dat <= 8'h00;
               acc_we  <= 1'b0;
            end
            StStopPoll: if (acc_done) begin
               if (!acc_rdata[SR_BUSY]) begin
                  state <= StDone;
               end else if (cnt >= POLL_TIMEOUT) begin
                  err_o <= ErrTimeout;
                  state <= StDone;
               end else begin
                  start <= 1'b1;
               end
            end
            StDone: begin
               done_o  <= 1'b1;
               ready_o <= 1'b1;
               phase   <= 2'd0;
               state   <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural model of the I2C core's register port and
// a transaction-level reference that predicts register writes, error code and read data.
module tb_i2c_reg_sequencer;

   localparam logic [15:0] PRESCALE = 16'h0035;
   localparam int          TMO      = 100;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic       req_i = 1'b0;
   logic       req_rnw_i = 1'b0;
   logic [6:0] req_dev_i = 7'd0;
   logic [7:0] req_reg_i = 8'h00;
   logic [7:0] req_wdata_i = 8'h00;
   logic       ready_o, done_o, m_we_o, m_stb_o;
   logic [1:0] err_o;
   logic [7:0] rdata_o, m_dat_o;
   logic [2:0] m_adr_o;
   logic [7:0] m_dat_i;
   logic       m_ack_i;

   i2c_reg_sequencer #(
      .PRESCALE     (PRESCALE),
      .POLL_TIMEOUT (20'(TMO))
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .req_i       (req_i),
      .req_rnw_i   (req_rnw_i),
      .req_dev_i   (req_dev_i),
      .req_reg_i   (req_reg_i),
      .req_wdata_i (req_wdata_i),
      .ready_o     (ready_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .rdata_o     (rdata_o),
      .m_adr_o     (m_adr_o),
      .m_dat_o     (m_dat_o),
      .m_we_o      (m_we_o),
      .m_stb_o     (m_stb_o),
      .m_dat_i     (m_dat_i),
      .m_ack_i     (m_ack_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int n_tests = 0;
   int n_fail = 0;

   // Core model state: every register write is logged as {adr, dat}.
   logic [10:0] wlog[$];
   int          cr_cnt = 0, cur_k = -1, tip_left = 0;
   int          nack_at = -1, al_at = -1, stuck_at = -1;
   logic [7:0]  cur_cr = 8'h00;
   logic [7:0]  rx_byte = 8'h00;
   int          done_cnt = 0;

   always @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         m_ack_i <= 1'b0;
         m_dat_i <= 8'h00;
         tip_left = 0;
         cur_cr   = 8'h00;
      end else begin
         m_ack_i <= m_stb_o && !m_ack_i;
         if (m_stb_o && !m_ack_i) begin
            if (m_we_o) begin
               wlog.push_back({m_adr_o, m_dat_o});
               if (m_adr_o == 3'd4) begin
                  cur_cr   = m_dat_o;
                  cur_k    = cr_cnt;
                  cr_cnt   = cr_cnt + 1;
                  tip_left = int'($urandom_range(0, 3));
               end
            end else if (m_adr_o == 3'd4) begin
               if (cur_cr == 8'h40) begin
                  m_dat_i <= {1'b0, tip_left > 0, 6'b0};
               end else begin
                  // The master's own NACK on the last read byte shows up as RxACK=1.
                  m_dat_i <= {(cur_k == nack_at) || (cur_k == al_at) || (cur_cr == 8'h68),
                              1'b1, cur_k == al_at, 3'b0,
                              (cur_k == stuck_at) || (tip_left > 0), 1'b0};
               end
               if (tip_left > 0) tip_left = tip_left - 1;
            end else if (m_adr_o == 3'd3) begin
               m_dat_i <= rx_byte;
            end else begin
               m_dat_i <= 8'h00;
            end
         end
      end
   end

   always @(posedge wb_clk_i) if (done_o) done_cnt = done_cnt + 1;

   // Reference model: expected register writes and error code of one transaction.
   logic [10:0] exp_q[$];
   logic [1:0]  exp_err;
   logic [7:0]  last_rdata = 8'h00;

   task automatic build_expect(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                               input logic [7:0] wd, input int kind, input int k);
      logic [7:0] bytes[3];
      logic [7:0] cmds[4];
      int nph;
      bytes[0] = {dev, 1'b0};
      bytes[1] = rg;
      bytes[2] = rnw ? {dev, 1'b1} : wd;
      cmds[0] = 8'h90;
      cmds[1] = 8'h10;
      cmds[2] = rnw ? 8'h90 : 8'h50;
      cmds[3] = 8'h68;
      nph = rnw ? 4 : 3;
      exp_q.delete();
      exp_err = 2'd0;
      for (int p = 0; p < nph; p++) begin
         if (p < 3) exp_q.push_back({3'd3, bytes[p]});
         exp_q.push_back({3'd4, cmds[p]});
         if (kind != 0 && p == k) begin
            exp_q.push_back({3'd4, 8'h40});
            exp_err = 2'(kind);
            break;
         end
      end
   endtask

   function automatic int log_diff(input int base);
      if (wlog.size() - base != exp_q.size()) return -2;
      foreach (exp_q[i]) if (wlog[base + i] !== exp_q[i]) return i;
      return -1;
   endfunction

   bit         obs_got, obs_fell, obs_back;
   int         obs_lat, obs_base, obs_pulses;
   logic [1:0] obs_err;
   logic [7:0] obs_rdata;

   task automatic do_req(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd, input int kind, input int k);
      int d0;
      for (int i = 0; i < 200 && !ready_o; i++) begin
         @(posedge wb_clk_i); #1;
      end
      nack_at  = (kind == 1) ? cr_cnt + k : -1;
      al_at    = (kind == 2) ? cr_cnt + k : -1;
      stuck_at = (kind == 3) ? cr_cnt + k : -1;
      obs_base = wlog.size();
      d0 = done_cnt;
      req_rnw_i = rnw; req_dev_i = dev; req_reg_i = rg; req_wdata_i = wd; req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      req_i = 1'b0;
      obs_fell = !ready_o;
      obs_got = 1'b0;
      obs_lat = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(posedge wb_clk_i); #1;
         if (done_o) begin
            obs_got = 1'b1;
            obs_lat = i;
            break;
         end
      end
      obs_err = err_o;
      obs_rdata = rdata_o;
      obs_back = ready_o;
      @(posedge wb_clk_i); #1;
      obs_pulses = done_cnt - d0;
      nack_at = -1; al_at = -1; stuck_at = -1;
   endtask

   task automatic test_reset();
      bit got = 1'b0;
      wb_rst_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1;
      n_tests++;
      if ({ready_o, done_o, err_o, rdata_o, m_adr_o, m_dat_o, m_we_o, m_stb_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b done=%b err=%0d rd=%h adr=%0d dat=%h we=%b stb=%b want all 0",
                  ready_o, done_o, err_o, rdata_o, m_adr_o, m_dat_o, m_we_o, m_stb_o);
      end
      wb_rst_i = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge wb_clk_i); #1;
         if (ready_o) begin got = 1'b1; break; end
      end
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL reset_ready: got 0 want 1 within 100 cycles"); end
      exp_q.delete();
      exp_q.push_back({3'd0, PRESCALE[7:0]});
      exp_q.push_back({3'd1, PRESCALE[15:8]});
      exp_q.push_back({3'd2, 8'h80});
      n_tests++;
      if (log_diff(0) != -1) begin
         n_fail++;
         $display("FAIL reset_init_writes: got %0d writes (diff %0d) want 3", wlog.size(), log_diff(0));
      end
   endtask

   task automatic test_transactions(input bit rnw, input int count);
      logic [6:0] dev;
      logic [7:0] rg, wd;
      for (int n = 0; n < count; n++) begin
         dev = (n == 0) ? 7'h4C : 7'($urandom);
         rg  = (n == 0) ? (rnw ? 8'h05 : 8'h12) : 8'($urandom);
         wd  = (n == 0) ? 8'hA5 : 8'($urandom);
         rx_byte = (n == 0) ? 8'h3C : 8'($urandom);
         build_expect(rnw, dev, rg, wd, 0, 0);
         do_req(rnw, dev, rg, wd, 0, 0);
         if (rnw) last_rdata = rx_byte;
         n_tests++;
         if (!obs_got || obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: got done=%b err=%0d want done=1 err=%0d",
                     rnw ? "read" : "write", obs_got, obs_err, exp_err);
         end
         n_tests++;
         if (log_diff(obs_base) != -1) begin
            n_fail++;
            $display("FAIL %s_writes: got diff at %0d want full match", rnw ? "read" : "write",
                     log_diff(obs_base));
         end
         n_tests++;
         if (obs_rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h want %h", rnw ? "read" : "write", obs_rdata, last_rdata);
         end
         n_tests++;
         if ({obs_fell, obs_back} !== 2'b11 || obs_pulses != 1) begin
            n_fail++;
            $display("FAIL %s_handshake: got fell=%b back=%b pulses=%0d want 1 1 1",
                     rnw ? "read" : "write", obs_fell, obs_back, obs_pulses);
         end
      end
   endtask

   task automatic test_errors(input int count);
      bit rnw;
      int kind, k;
      logic [6:0] dev;
      for (int n = 0; n < count; n++) begin
         rnw  = (n == 0) ? 1'b0 : 1'($urandom);
         kind = (n == 0) ? 1 : int'($urandom_range(1, 2));
         k    = (n == 0) ? 0 : (kind == 1) ? int'($urandom_range(0, 2))
                                           : int'($urandom_range(0, rnw ? 3 : 2));
         dev  = (n == 0) ? 7'h4C : 7'($urandom);
         rx_byte = 8'($urandom);
         build_expect(rnw, dev, 8'($urandom), 8'($urandom), 0, 0);
         build_expect(rnw, dev, exp_q[2][7:0], rnw ? 8'h00 : 8'($urandom), kind, k);
         do_req(rnw, dev, exp_q[2][7:0], (exp_q.size() > 4) ? exp_q[4][7:0] : 8'h00, kind, k);
         n_tests++;
         if (!obs_got || obs_err !== exp_err) begin
            n_fail++;
            $display("FAIL error_code: got done=%b err=%0d want done=1 err=%0d (kind %0d phase %0d)",
                     obs_got, obs_err, exp_err, kind, k);
         end
         n_tests++;
         if (log_diff(obs_base) != -1) begin
            n_fail++;
            $display("FAIL error_writes: got diff at %0d want full match (kind %0d phase %0d)",
                     log_diff(obs_base), kind, k);
         end
         n_tests++;
         if (obs_rdata !== last_rdata || obs_pulses != 1) begin
            n_fail++;
            $display("FAIL error_hold: got rdata=%h pulses=%0d want rdata=%h pulses=1",
                     obs_rdata, obs_pulses, last_rdata);
         end
      end
   endtask

   task automatic test_timeout();
      int k;
      logic [7:0] rg;
      for (int n = 0; n < 3; n++) begin
         k = (n == 0) ? 0 : int'($urandom_range(0, 2));
         rg = 8'($urandom);
         build_expect(1'b0, 7'h21, rg, 8'h5A, 3, k);
         do_req(1'b0, 7'h21, rg, 8'h5A, 3, k);
         n_tests++;
         if (!obs_got || obs_err !== 2'd3) begin
            n_fail++;
            $display("FAIL timeout_err: got done=%b err=%0d want done=1 err=3", obs_got, obs_err);
         end
         n_tests++;
         if (obs_lat < TMO || obs_lat > TMO + 60 * (k + 1)) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", obs_lat, TMO,
                     TMO + 60 * (k + 1));
         end
         n_tests++;
         if (log_diff(obs_base) != -1) begin
            n_fail++;
            $display("FAIL timeout_writes: got diff at %0d want full match", log_diff(obs_base));
         end
      end
      build_expect(1'b0, 7'h21, 8'h33, 8'h44, 0, 0);
      do_req(1'b0, 7'h21, 8'h33, 8'h44, 0, 0);
      n_tests++;
      if (!obs_got || obs_err !== 2'd0 || log_diff(obs_base) != -1) begin
         n_fail++;
         $display("FAIL timeout_recovery: got done=%b err=%0d diff=%0d want 1 0 -1",
                  obs_got, obs_err, log_diff(obs_base));
      end
   endtask

   task automatic test_busy_ignore();
      int base, d0;
      bit got = 1'b0;
      build_expect(1'b0, 7'h4C, 8'h12, 8'hA5, 0, 0);
      base = wlog.size();
      d0 = done_cnt;
      req_rnw_i = 1'b0; req_dev_i = 7'h4C; req_reg_i = 8'h12; req_wdata_i = 8'hA5; req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      req_rnw_i = 1'b1; req_dev_i = 7'h11; req_reg_i = 8'h77;
      repeat (15) @(posedge wb_clk_i);
      #1;
      n_tests++;
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b want 0", ready_o); end
      req_i = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge wb_clk_i); #1;
         if (done_o) begin got = 1'b1; break; end
      end
      repeat (60) @(posedge wb_clk_i);
      #1;
      n_tests++;
      if (!got || log_diff(base) != -1 || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL busy_ignored: got done=%b diff=%0d pulses=%0d want 1 -1 1",
                  got, log_diff(base), done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      int base, d0;
      bit got = 1'b0;
      rx_byte = 8'h96;
      req_rnw_i = 1'b1; req_dev_i = 7'h4C; req_reg_i = 8'h05; req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      req_i = 1'b0;
      repeat (12) @(posedge wb_clk_i);
      #1;
      req_rnw_i = 1'b0; req_dev_i = 7'h2B; req_reg_i = 8'hEE; req_wdata_i = 8'h01; req_i = 1'b1;
      @(posedge wb_clk_i); #1;
      req_i = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #2;
      wb_rst_i = 1'b1;
      #1;
      n_tests++;
      if ({ready_o, done_o, err_o, rdata_o, m_adr_o, m_dat_o, m_we_o, m_stb_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got rdy=%b done=%b err=%0d adr=%0d dat=%h we=%b stb=%b want all 0",
                  ready_o, done_o, err_o, m_adr_o, m_dat_o, m_we_o, m_stb_o);
      end
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      last_rdata = 8'h00;
      base = wlog.size();
      d0 = done_cnt;
      for (int i = 0; i < 100; i++) begin
         @(posedge wb_clk_i); #1;
         if (ready_o) begin got = 1'b1; break; end
      end
      repeat (60) @(posedge wb_clk_i);
      #1;
      exp_q.delete();
      exp_q.push_back({3'd0, PRESCALE[7:0]});
      exp_q.push_back({3'd1, PRESCALE[15:8]});
      exp_q.push_back({3'd2, 8'h80});
      n_tests++;
      if (!got || log_diff(base) != -1 || done_cnt != d0 || rdata_o !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_reinit: got ready=%b diff=%0d pulses=%0d rdata=%h want 1 -1 0 00",
                  got, log_diff(base), done_cnt - d0, rdata_o);
      end
   endtask

   initial begin
      test_reset();
      test_transactions(1'b0, 6);
      test_transactions(1'b1, 6);
      test_errors(10);
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
      test_transactions(1'b1, 2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
